// File: rtl/ysyx_220066_pkg.sv
// Shared types and defaults for the ysyx_220066 writeback/commit path.
package ysyx_220066_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned RA_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_DONE = 2'd1,
    ST_HALT_ERR  = 2'd2
  } wb_state_t;

  // One retired instruction as seen by the register file and commit monitor.
  typedef struct packed {
    logic                wen;
    logic [RA_W_DEF-1:0] rd;
    logic [XLEN_DEF-1:0] data;
    logic [XLEN_DEF-1:0] nxtpc;
    logic                done;
    logic                error;
  } commit_rec_t;

endpackage

// File: rtl/ysyx_220066_rr_arbiter.sv
// Request arbiter: fixed priority (index 0 highest) or round-robin from a rotating pointer.
module ysyx_220066_rr_arbiter
  import ysyx_220066_pkg::*;
#(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned RR_MODE = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CH-1:0]                 req,
  output logic [NUM_CH-1:0]                 grant_c,
  output logic [$clog2(NUM_CH)-1:0]         idx_c,
  output logic                              valid_c
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);
  localparam int unsigned SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] ptr_q;
  logic [SUM_W-1:0] cand;

  // Walk the channels starting at the pointer (or at 0), taking the first requester.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (RR_MODE != 0) begin
        cand = {1'b0, ptr_q} + SUM_W'(k);
      end else begin
        cand = SUM_W'(k);
      end
      if (cand >= SUM_W'(NUM_CH)) begin
        cand = cand - SUM_W'(NUM_CH);
      end
      if (!valid_c && req[cand[IDX_W-1:0]]) begin
        valid_c                    = 1'b1;
        idx_c                      = cand[IDX_W-1:0];
        grant_c[cand[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (valid_c) begin
      ptr_q <= (idx_c == IDX_W'(NUM_CH - 1)) ? '0 : idx_c + IDX_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_220066_wb_arbiter.sv
// Writeback/commit arbiter: merges producer channels into one register-file
// write port and commit record, halting for good on a committed done or error.
module ysyx_220066_wb_arbiter
  import ysyx_220066_pkg::*;
#(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned RA_W    = RA_W_DEF,
  parameter int unsigned RR_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH-1:0]        in_wen,
  input  logic [NUM_CH*RA_W-1:0]   in_rd,
  input  logic [NUM_CH*XLEN-1:0]   in_data,
  input  logic [NUM_CH*XLEN-1:0]   in_nxtpc,
  input  logic [NUM_CH-1:0]        in_done,
  input  logic [NUM_CH-1:0]        in_error,
  output logic                     rf_wen,
  output logic [RA_W-1:0]          rf_rd,
  output logic [XLEN-1:0]          rf_data,
  output logic                     commit_valid,
  output logic [XLEN-1:0]          commit_nxtpc,
  output logic                     commit_done,
  output logic                     commit_error,
  output logic                     halted
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  wb_state_t          state_q;
  logic               run_c;
  logic [NUM_CH-1:0]  req_c;
  logic [NUM_CH-1:0]  grant_c;
  logic [IDX_W-1:0]   g_idx_c;
  logic               g_valid_c;

  logic               sel_wen;
  logic [RA_W-1:0]    sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic [XLEN-1:0]    sel_nxtpc;
  logic               sel_done;
  logic               sel_error;

  // Nothing is offered to the arbiter during reset or once halted.
  assign run_c    = rst && (state_q == ST_RUN);
  assign req_c    = in_valid & {NUM_CH{run_c}};
  assign in_ready = grant_c;

  ysyx_220066_rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_c),
    .grant_c (grant_c),
    .idx_c   (g_idx_c),
    .valid_c (g_valid_c)
  );

  always_comb begin
    sel_wen   = in_wen[g_idx_c];
    sel_rd    = in_rd[int'(g_idx_c)*RA_W +: RA_W];
    sel_data  = in_data[int'(g_idx_c)*XLEN +: XLEN];
    sel_nxtpc = in_nxtpc[int'(g_idx_c)*XLEN +: XLEN];
    sel_done  = in_done[g_idx_c];
    sel_error = in_error[g_idx_c];
  end

  // Commit register and halt FSM; the halting instruction still commits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      rf_wen       <= 1'b0;
      rf_rd        <= '0;
      rf_data      <= '0;
      commit_valid <= 1'b0;
      commit_nxtpc <= '0;
      commit_done  <= 1'b0;
      commit_error <= 1'b0;
      halted       <= 1'b0;
    end else if (g_valid_c) begin
      commit_valid <= 1'b1;
      rf_wen       <= sel_wen && (sel_rd != '0) && !sel_error;
      rf_rd        <= sel_rd;
      rf_data      <= sel_data;
      commit_nxtpc <= sel_nxtpc;
      commit_done  <= sel_done;
      commit_error <= sel_error;
      if (sel_error) begin
        state_q <= ST_HALT_ERR;
        halted  <= 1'b1;
      end else if (sel_done) begin
        state_q <= ST_HALT_DONE;
        halted  <= 1'b1;
      end
    end else begin
      commit_valid <= 1'b0;
      rf_wen       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_220066_wb_arbiter.sv
// Directed bench: round-robin and fixed-priority instances driven by the same producer stimulus.
module tb_ysyx_220066_wb_arbiter;
  import ysyx_220066_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned XL = 64;
  localparam int unsigned RW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    valid, wen, done, err;
  logic [N*RW-1:0] rd;
  logic [N*XL-1:0] data, nxtpc;

  logic [N-1:0]  r_ready, f_ready;
  logic          r_rf_wen, f_rf_wen;
  logic [RW-1:0] r_rf_rd, f_rf_rd;
  logic [XL-1:0] r_rf_data, f_rf_data, r_nxtpc, f_nxtpc;
  logic          r_cv, f_cv, r_cd, f_cd, r_ce, f_ce, r_halt, f_halt;

  int n_pass  = 0;
  int n_total = 0;
  int pulses;

  always #5 clk = ~clk;

  ysyx_220066_wb_arbiter #(.NUM_CH(N), .XLEN(XL), .RA_W(RW), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(valid), .in_ready(r_ready), .in_wen(wen),
    .in_rd(rd), .in_data(data), .in_nxtpc(nxtpc), .in_done(done), .in_error(err),
    .rf_wen(r_rf_wen), .rf_rd(r_rf_rd), .rf_data(r_rf_data), .commit_valid(r_cv),
    .commit_nxtpc(r_nxtpc), .commit_done(r_cd), .commit_error(r_ce), .halted(r_halt)
  );

  ysyx_220066_wb_arbiter #(.NUM_CH(N), .XLEN(XL), .RA_W(RW), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(valid), .in_ready(f_ready), .in_wen(wen),
    .in_rd(rd), .in_data(data), .in_nxtpc(nxtpc), .in_done(done), .in_error(err),
    .rf_wen(f_rf_wen), .rf_rd(f_rf_rd), .rf_data(f_rf_data), .commit_valid(f_cv),
    .commit_nxtpc(f_nxtpc), .commit_done(f_cd), .commit_error(f_ce), .halted(f_halt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    valid = '0; wen = '0; done = '0; err = '0;
    rd = '0; data = '0; nxtpc = '0;
  endtask

  task automatic set_ch(input int i, input logic w, input logic [RW-1:0] r,
                        input logic [XL-1:0] d, input logic [XL-1:0] pc,
                        input logic dn, input logic er);
    valid[i]        = 1'b1;
    wen[i]          = w;
    rd[i*RW +: RW]  = r;
    data[i*XL +: XL]  = d;
    nxtpc[i*XL +: XL] = pc;
    done[i]         = dn;
    err[i]          = er;
  endtask

  initial begin
    // 1: reset with every channel requesting, then a single ch0 writeback
    clear_all();
    rst = 1'b0;
    for (int i = 0; i < int'(N); i++) set_ch(i, 1'b1, RW'(i + 1), 64'(i), 64'(i), 1'b0, 1'b0);
    tick(); tick();
    chk("rst_rr_ready", 64'(r_ready), 64'h0);
    chk("rst_fp_ready", 64'(f_ready), 64'h0);
    chk("rst_cv", 64'(r_cv), 64'h0);
    chk("rst_rf_wen", 64'(r_rf_wen), 64'h0);
    chk("rst_halted", 64'(r_halt), 64'h0);

    rst = 1'b1;
    clear_all();
    set_ch(0, 1'b1, 5'd5, 64'h1234, 64'h8000_0004, 1'b0, 1'b0);
    #1;
    chk("t1_ready", 64'(r_ready), 64'b001);
    tick();
    chk("t1_cv", 64'(r_cv), 64'h1);
    chk("t1_rf_wen", 64'(r_rf_wen), 64'h1);
    chk("t1_rf_rd", 64'(r_rf_rd), 64'd5);
    chk("t1_rf_data", r_rf_data, 64'h1234);
    chk("t1_nxtpc", r_nxtpc, 64'h8000_0004);
    chk("t1_fp_rf_data", f_rf_data, 64'h1234);

    // 2: write to x0 commits but does not write
    clear_all();
    set_ch(1, 1'b1, 5'd0, 64'hFFFF, 64'h8000_0008, 1'b0, 1'b0);
    #1;
    chk("t2_ready", 64'(r_ready), 64'b010);
    tick();
    chk("t2_cv", 64'(r_cv), 64'h1);
    chk("t2_rf_wen", 64'(r_rf_wen), 64'h0);
    chk("t2_rf_data", r_rf_data, 64'hFFFF);

    // 3: all channels valid; rotation vs fixed priority
    rst = 1'b0;
    tick();
    rst = 1'b1;
    clear_all();
    for (int i = 0; i < int'(N); i++)
      set_ch(i, 1'b1, RW'(10 + i), 64'(16'hA0 + i), 64'(32'h8000_1000 + 4 * i), 1'b0, 1'b0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("t3_rr_ready", 64'(r_ready), 64'(1) << (c % 3));
      chk("t3_fp_ready", 64'(f_ready), 64'b001);
      tick();
      chk("t3_rr_rd", 64'(r_rf_rd), 64'(10 + (c % 3)));
      chk("t3_fp_rd", 64'(f_rf_rd), 64'd10);
      if (r_cv) pulses++;
    end
    chk("t3_pulses", 64'(pulses), 64'd6);

    // 4: fixed priority keeps ch2 stalled while ch0 requests
    clear_all();
    set_ch(0, 1'b1, 5'd20, 64'hC0, 64'h8000_2000, 1'b0, 1'b0);
    set_ch(2, 1'b1, 5'd22, 64'hC2, 64'h8000_2008, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_fp_ready", 64'(f_ready), 64'b001);
      tick();
      chk("t4_fp_rd", 64'(f_rf_rd), 64'd20);
    end
    valid[0] = 1'b0;
    #1;
    chk("t4_fp_ready_ch2", 64'(f_ready), 64'b100);
    tick();
    chk("t4_fp_cv", 64'(f_cv), 64'h1);
    chk("t4_fp_rd_ch2", 64'(f_rf_rd), 64'd22);
    chk("t4_fp_data_ch2", f_rf_data, 64'hC2);

    // 5: done on ch1 halts both instances until reset
    rst = 1'b0;
    clear_all();
    tick();
    rst = 1'b1;
    set_ch(1, 1'b1, 5'd7, 64'h77, 64'h8000_0100, 1'b1, 1'b0);
    #1;
    chk("t5_ready", 64'(r_ready), 64'b010);
    tick();
    chk("t5_cv", 64'(r_cv), 64'h1);
    chk("t5_done", 64'(r_cd), 64'h1);
    chk("t5_halted", 64'(r_halt), 64'h1);
    chk("t5_nxtpc", r_nxtpc, 64'h8000_0100);
    chk("t5_fp_halted", 64'(f_halt), 64'h1);
    clear_all();
    for (int i = 0; i < int'(N); i++) set_ch(i, 1'b1, RW'(i + 1), 64'(i), 64'(i), 1'b0, 1'b0);
    #1;
    chk("t5_halt_rr_ready", 64'(r_ready), 64'h0);
    chk("t5_halt_fp_ready", 64'(f_ready), 64'h0);
    tick();
    chk("t5_halt_cv", 64'(r_cv), 64'h0);
    chk("t5_halt_still", 64'(r_halt), 64'h1);
    tick();
    chk("t5_halt_cv2", 64'(r_cv), 64'h0);
    rst = 1'b0;
    tick();
    chk("t5_rst_halted", 64'(r_halt), 64'h0);

    // 6: error and done together on ch0 -> error halt, no write
    rst = 1'b1;
    clear_all();
    set_ch(0, 1'b1, 5'd3, 64'h33, 64'h8000_0200, 1'b1, 1'b1);
    #1;
    chk("t6_ready", 64'(r_ready), 64'b001);
    tick();
    chk("t6_cv", 64'(r_cv), 64'h1);
    chk("t6_rf_wen", 64'(r_rf_wen), 64'h0);
    chk("t6_error", 64'(r_ce), 64'h1);
    chk("t6_done", 64'(r_cd), 64'h1);
    chk("t6_halted", 64'(r_halt), 64'h1);
    chk("t6_state", 64'(dut_rr.state_q), 64'(ST_HALT_ERR));
    rst = 1'b0;
    tick();
    chk("t6_rst_state", 64'(dut_rr.state_q), 64'(ST_RUN));
    chk("t6_rst_ptr", 64'(dut_rr.u_arb.ptr_q), 64'h0);
    rst = 1'b1;
    clear_all();
    for (int i = 0; i < int'(N); i++) set_ch(i, 1'b1, RW'(i + 1), 64'(i), 64'(i), 1'b0, 1'b0);
    #1;
    chk("t6_post_ready", 64'(r_ready), 64'b001);
    tick();
    chk("t6_post_cv", 64'(r_cv), 64'h1);
    chk("t6_post_rd", 64'(r_rf_rd), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
